fpnew_opgroup_out_buffer: RTL and testbench

// - Result buffer directly downstream of an opgroup block's output arbiter.
// - Decouples the FPU's output handshake from opgroup backpressure.
// - Stores {result, status, extension bit, tag} in a circular FIFO.
// - Keeps a sticky fflags accumulator: the OR of status over every delivered result.

---
 rtl/fpnew_opgroup_out_buffer.sv | 139 +++++++++++++
 tb/tb_fpnew_opgroup_out_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_opgroup_out_buffer.sv
// Opgroup result FIFO with a sticky fflags accumulator over delivered results.
// Define FPNEW_OUTBUF_BYPASS_EN to let an input fall through an empty buffer in the same cycle.
package fpnew_outbuf_pkg;
    typedef logic [4:0] status_t; // {NV, DZ, OF, UF, NX}
endpackage

module fpnew_opgroup_out_buffer
    import fpnew_outbuf_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 2,
    parameter type         TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [Width-1:0]           in_result_i,
    input  status_t                    in_status_i,
    input  logic                       in_ext_bit_i,
    input  TagType                     in_tag_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [Width-1:0]           result_o,
    output status_t                    status_o,
    output logic                       extension_bit_o,
    output TagType                     tag_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output status_t                    fflags_o,
    input  logic                       fflags_clr_i,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned UsageW = $clog2(Depth + 1);
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
        TagType           tag;
    } entry_t;

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [UsageW-1:0] usage_q, usage_d;
    status_t           fflags_q, fflags_d;

    entry_t in_entry, head, head_out;
    logic   empty, head_valid, bypass;
    logic   push, pop, store, pop_mem;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign in_entry = '{result: in_result_i, status: in_status_i,
                        ext_bit: in_ext_bit_i, tag: in_tag_i};
    assign empty    = (usage_q == '0);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        head_valid = !empty;
        bypass     = 1'b0;
`ifdef FPNEW_OUTBUF_BYPASS_EN
        if (empty) begin
            head       = in_entry;
            head_valid = in_valid_i;
            bypass     = 1'b1;
        end
`endif
        if (flush_i) begin
            head_valid = 1'b0;
            bypass     = 1'b0;
        end
    end

    // Ready depends on stored occupancy only, so a full buffer refuses a push even if it pops.
    assign in_ready_o = (usage_q < UsageW'(Depth));
    assign push       = in_valid_i & in_ready_o & ~flush_i;
    assign pop        = head_valid & out_ready_i;
    assign store      = push & ~(bypass & out_ready_i);
    assign pop_mem    = pop & ~bypass;

    always_comb begin
        usage_d = usage_q;
        if (store && !pop_mem) begin
            usage_d = usage_q + 1'b1;
        end else if (!store && pop_mem) begin
            usage_d = usage_q - 1'b1;
        end
    end

    assign fflags_d = (fflags_clr_i ? status_t'('0) : fflags_q)
                    | (pop ? head.status : status_t'('0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (store)   wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_mem) rd_ptr_q <= ptr_inc(rd_ptr_q);
            usage_q <= usage_d;
        end
    end

    // Flags survive a flush: only reset or an explicit clear drops them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    // NOTE: storage has no reset; outputs are zeroed whenever the head is invalid instead.
    always_ff @(posedge clk_i) begin
        if (store) mem_q[wr_ptr_q] <= in_entry;
    end

    assign head_out        = head_valid ? head : '0;
    assign result_o        = head_out.result;
    assign status_o        = head_out.status;
    assign extension_bit_o = head_out.ext_bit;
    assign tag_o           = head_out.tag;
    assign out_valid_o     = head_valid;
    assign fflags_o        = fflags_q;
    assign usage_o         = usage_q;
    assign busy_o          = !empty;

endmodule

// File: tb/tb_fpnew_opgroup_out_buffer.sv
// Self-checking bench for fpnew_opgroup_out_buffer: directed scenarios plus a random
// phase, all compared against a queue-based model of the buffer.
module tb_fpnew_opgroup_out_buffer;

    localparam int unsigned Width  = 32;
    localparam int unsigned Depth  = 2;
    localparam int unsigned UsageW = $clog2(Depth + 1);

    typedef logic [7:0] tag_t;
    typedef struct {
        logic [31:0] result;
        logic [4:0]  status;
        logic        ext;
        tag_t        tag;
    } item_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [Width-1:0]  in_result = '0;
    logic [4:0]        in_status = '0;
    logic              in_ext_bit = 1'b0;
    tag_t              in_tag = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [Width-1:0]  result;
    logic [4:0]        status;
    logic              extension_bit;
    tag_t              tag;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [4:0]        fflags;
    logic              fflags_clr = 1'b0;
    logic [UsageW-1:0] usage;
    logic              busy;

    item_t      model_q[$];
    logic [4:0] model_fflags = '0;
    tag_t       delivered_q[$];
    int         checks = 0;
    int         passed = 0;

    fpnew_opgroup_out_buffer #(
        .Width  (Width),
        .Depth  (Depth),
        .TagType(tag_t)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_result_i    (in_result),
        .in_status_i    (in_status),
        .in_ext_bit_i   (in_ext_bit),
        .in_tag_i       (in_tag),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .flush_i        (flush),
        .result_o       (result),
        .status_o       (status),
        .extension_bit_o(extension_bit),
        .tag_o          (tag),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .fflags_o       (fflags),
        .fflags_clr_i   (fflags_clr),
        .usage_o        (usage),
        .busy_o         (busy)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // One clock cycle: drive inputs, compare outputs against the model mid-cycle,
    // then advance the model by what the buffer is supposed to do at the edge.
    task automatic step(input logic v, input tag_t t, input logic [31:0] r, input logic [4:0] s,
                        input logic e, input logic rdy, input logic fl, input logic clr);
        item_t cur;
        item_t head;
        bit    exp_valid, byp, pop, push;
        in_valid   = v;
        in_tag     = t;
        in_result  = r;
        in_status  = s;
        in_ext_bit = e;
        out_ready  = rdy;
        flush      = fl;
        fflags_clr = clr;
        @(negedge clk_i);
        cur       = '{r, s, e, t};
        exp_valid = (model_q.size() > 0) && !fl;
        byp       = 1'b0;
`ifdef FPNEW_OUTBUF_BYPASS_EN
        if (model_q.size() == 0 && !fl) begin
            exp_valid = v;
            byp       = 1'b1;
        end
`endif
        head = byp ? cur : (model_q.size() > 0 ? model_q[0] : cur);
        check("out_valid", out_valid, exp_valid);
        check("in_ready", in_ready, model_q.size() < Depth);
        check("usage", usage, model_q.size());
        check("busy", busy, model_q.size() != 0);
        check("fflags", fflags, model_fflags);
        if (exp_valid) begin
            check("result", result, head.result);
            check("status", status, head.status);
            check("ext_bit", extension_bit, head.ext);
            check("tag", tag, head.tag);
        end
        pop  = exp_valid && rdy;
        push = v && (model_q.size() < Depth) && !fl;
        if (clr) model_fflags = '0;
        if (pop) begin
            model_fflags = model_fflags | head.status;
            delivered_q.push_back(head.tag);
        end
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop && !byp) void'(model_q.pop_front());
            if (push && !(byp && pop)) model_q.push_back(cur);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 8'h00, 32'h0, 5'b0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        int found;
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_usage", usage, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_fflags", fflags, 5'b0);
        check("rst_result", result, 32'h0);
        check("rst_tag", tag, 8'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill to Depth, a third push is held, then drain in order
        step(1'b1, 8'd1, 32'h1111_0001, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd2, 32'h2222_0002, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fill_ready_low", in_ready, 1'b0);
        step(1'b1, 8'd3, 32'h3333_0003, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        delivered_q.delete();
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("fill_count", delivered_q.size(), 2);
        check("fill_first", delivered_q[0], 8'd1);
        check("fill_second", delivered_q[1], 8'd2);

        // Back-to-back push+pop pairs wrap the pointers
        delivered_q.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, tag_t'(i), 32'hA000_0000 + i, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("wrap_usage_bound", usage <= Depth, 1'b1);
        end
        idle(1'b1);
        idle(1'b1);
        check("wrap_count", delivered_q.size(), 5);
        for (int i = 0; i < 5; i++) check("wrap_order", delivered_q[i], tag_t'(i));

        // Sticky flags, then clear concurrent with a pop
        step(1'b0, 8'd0, 32'h0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'd30, 32'h3000_0000, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd31, 32'h3100_0000, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("fflags_or", fflags, 5'b10001);
        step(1'b1, 8'd32, 32'h3200_0000, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 32'h0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("fflags_clr_pop", fflags, 5'b00100);

        // Flush with two entries held and a concurrent push
        step(1'b1, 8'd10, 32'h1000_000A, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd11, 32'h1000_000B, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        delivered_q.delete();
        step(1'b1, 8'd12, 32'h1000_000C, 5'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_usage", usage, 0);
        check("flush_fflags_kept", fflags, 5'b00100);
        idle(1'b1);
        idle(1'b1);
        found = 0;
        foreach (delivered_q[i]) if (delivered_q[i] == 8'd12) found++;
        check("flush_dropped_tag", found, 0);
        check("flush_nothing_out", delivered_q.size(), 0);

        // Latency on an empty buffer (fall-through when bypass is built in)
        step(1'b1, 8'd40, 32'h3F80_0000, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef FPNEW_OUTBUF_BYPASS_EN
        check("bypass_usage", usage, 0);
`else
        check("latency_valid", out_valid, 1'b1);
        check("latency_result", result, 32'h3F80_0000);
`endif
        idle(1'b1);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, tag_t'($urandom), $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end
        idle(1'b1);
        idle(1'b1);

        // Reset in the middle of a stream with two entries held
        step(1'b1, 8'd20, 32'h2000_0000, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd21, 32'h2100_0000, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'd22, 32'h2200_0000, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pre_reset_usage", usage, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_usage", usage, 0);
        check("midrst_fflags", fflags, 5'b0);
        model_q.delete();
        model_fflags = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        idle(1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
